f_cc_unit: RTL and testbench

- Consumer end of the FP compare path: owns the eight FP condition codes (FCC0–7) and the FCSR cause/flag/enable fields.
- Records which FCC an in-flight C.cond will write, and commits the comparator's result/invalid outputs.
- Serves FCC reads to BC1T/BC1F/MOVT/MOVF consumers, with a stall while the targeted FCC is pending.
- Handles CTC1/CFC1 access to FCSR, FCCR, FEXR and FENR.

---
 rtl/f_cc_unit_pkg.sv | 33 +++
 rtl/f_cc_unit_fcsr_pack.sv | 44 ++++
 rtl/f_cc_unit.sv | 141 ++++++++++++++
 tb/tb_f_cc_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f_cc_unit_pkg.sv
// f_cc_unit shared definitions: FCSR field positions and CTC1/CFC1 selectors.
// Also consumed by the FP decode and exception units.
package f_cc_unit_pkg;

  localparam int unsigned NUM_CC = 8;

  localparam int unsigned FCSR_FCC0   = 23;
  localparam int unsigned FCSR_FCC_HI = 31;
  localparam int unsigned FCSR_FCC_LO = 25;
  localparam int unsigned FCSR_FS     = 24;
  localparam int unsigned FCSR_CAUSE  = 12;
  localparam int unsigned FCSR_EN     = 7;
  localparam int unsigned FCSR_FLAG   = 2;
  localparam int unsigned FCSR_RM     = 0;
  localparam int unsigned CAUSE_W     = 6;
  localparam int unsigned EXC_W       = 5;
  localparam int unsigned EXC_V       = 4;

  localparam logic [1:0] SEL_FCSR = 2'd0;
  localparam logic [1:0] SEL_FCCR = 2'd1;
  localparam logic [1:0] SEL_FEXR = 2'd2;
  localparam logic [1:0] SEL_FENR = 2'd3;

  typedef struct packed {
    logic [NUM_CC-1:0]  fcc;
    logic               fs;
    logic [CAUSE_W-1:0] cause;
    logic [EXC_W-1:0]   en;
    logic [EXC_W-1:0]   flag;
    logic [1:0]         rm;
  } fcsr_t;

endpackage

// File: rtl/f_cc_unit_fcsr_pack.sv
// f_cc_unit_fcsr_pack: combinational CFC1 read mux over the FCSR field
// registers, producing the FCSR, FCCR, FEXR and FENR views.
module f_cc_unit_fcsr_pack
  import f_cc_unit_pkg::*;
(
  input  fcsr_t       f_i,
  input  logic [1:0]  sel_i,
  output logic [31:0] data_o
);

  logic [31:0] fcsr;
  logic [31:0] fccr;
  logic [31:0] fexr;
  logic [31:0] fenr;

  always_comb begin
    fcsr = '0;
    fcsr[FCSR_FCC_HI:FCSR_FCC_LO] = f_i.fcc[7:1];
    fcsr[FCSR_FCC0] = f_i.fcc[0];
    fcsr[FCSR_FS] = f_i.fs;
    fcsr[FCSR_CAUSE +: CAUSE_W] = f_i.cause;
    fcsr[FCSR_EN +: EXC_W] = f_i.en;
    fcsr[FCSR_FLAG +: EXC_W] = f_i.flag;
    fcsr[FCSR_RM +: 2] = f_i.rm;

    fccr = {24'b0, f_i.fcc};

    fexr = '0;
    fexr[FCSR_CAUSE +: CAUSE_W] = f_i.cause;
    fexr[FCSR_FLAG +: EXC_W] = f_i.flag;

    fenr = {20'b0, f_i.en, 4'b0, f_i.fs, f_i.rm};

    data_o = fcsr;
    unique case (sel_i)
      SEL_FCSR: data_o = fcsr;
      SEL_FCCR: data_o = fccr;
      SEL_FEXR: data_o = fexr;
      SEL_FENR: data_o = fenr;
      default:  data_o = fcsr;
    endcase
  end

endmodule

// File: rtl/f_cc_unit.sv
// f_cc_unit: FP condition codes and FCSR, compare commit and FCC reads.
// Define FCC_BYPASS_EN to forward a committing result to FCC readers.
module f_cc_unit
  import f_cc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        iss_valid,
  input  logic [2:0]  iss_cc,
  input  logic        cmp_ready,
  input  logic        cmp_wait,
  input  logic        cmp_result,
  input  logic        cmp_invalid,
  output logic        busy,
  input  logic        rd_valid,
  input  logic [2:0]  rd_cc,
  input  logic        rd_tf,
  output logic        rd_ready,
  output logic        rd_taken,
  input  logic        cw_valid,
  input  logic [1:0]  cw_sel,
  input  logic [31:0] cw_data,
  output logic        cw_ready,
  input  logic [1:0]  cr_sel,
  output logic [31:0] cr_data,
  output logic        fpe_exc
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  logic [0:0] st_q, st_d;
  logic [2:0] pend_q, pend_d;
  logic       fpe_q, fpe_d;
  fcsr_t      r_q, r_d;

  logic commit;
  logic commit_ok;
  logic exc;
  logic byp;
  logic cw_fire;
  logic unused_ok;

  assign busy      = (st_q == S_PEND);
  assign cw_ready  = ~busy;
  assign commit    = busy & cmp_ready & ~cmp_wait;
  assign commit_ok = commit & ~flush;
  assign exc       = cmp_invalid & r_q.en[EXC_V];
  assign cw_fire   = cw_valid & cw_ready;
  assign fpe_exc   = fpe_q;
  assign unused_ok = ^{rd_valid, cw_data[22:18]};

`ifdef FCC_BYPASS_EN
  assign byp = commit_ok & ~exc & (pend_q == rd_cc);
`else
  assign byp = 1'b0;
`endif

  assign rd_ready = ~(busy & (pend_q == rd_cc)) | byp;
  assign rd_taken = (byp ? cmp_result : r_q.fcc[rd_cc]) == rd_tf;

  always_comb begin
    st_d   = st_q;
    pend_d = pend_q;
    if (flush) begin
      st_d = S_IDLE;
    end else if (st_q == S_IDLE) begin
      if (iss_valid) begin
        st_d   = S_PEND;
        pend_d = iss_cc;
      end
    end else if (commit) begin
      if (iss_valid) begin
        pend_d = iss_cc;
      end else begin
        st_d = S_IDLE;
      end
    end
  end

  always_comb begin
    r_d   = r_q;
    fpe_d = commit_ok & exc;
    if (commit_ok) begin
      r_d.cause = '0;
      r_d.cause[EXC_V] = cmp_invalid;
      if (!exc) begin
        r_d.fcc[pend_q] = cmp_result;
        r_d.flag[EXC_V] = r_q.flag[EXC_V] | cmp_invalid;
      end
    end
    if (cw_fire) begin
      unique case (1'b1)
        cw_sel == SEL_FCSR: begin
          r_d.fcc   = {cw_data[FCSR_FCC_HI:FCSR_FCC_LO],
                       cw_data[FCSR_FCC0]};
          r_d.fs    = cw_data[FCSR_FS];
          r_d.cause = cw_data[FCSR_CAUSE +: CAUSE_W];
          r_d.en    = cw_data[FCSR_EN +: EXC_W];
          r_d.flag  = cw_data[FCSR_FLAG +: EXC_W];
          r_d.rm    = cw_data[FCSR_RM +: 2];
        end
        cw_sel == SEL_FCCR: begin
          r_d.fcc = cw_data[NUM_CC-1:0];
        end
        cw_sel == SEL_FEXR: begin
          r_d.cause = cw_data[FCSR_CAUSE +: CAUSE_W];
          r_d.flag  = cw_data[FCSR_FLAG +: EXC_W];
        end
        cw_sel == SEL_FENR: begin
          r_d.en = cw_data[FCSR_EN +: EXC_W];
          r_d.fs = cw_data[2];
          r_d.rm = cw_data[1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q   <= S_IDLE;
      pend_q <= '0;
      fpe_q  <= 1'b0;
      r_q    <= '0;
    end else begin
      st_q   <= st_d;
      pend_q <= pend_d;
      fpe_q  <= fpe_d;
      r_q    <= r_d;
    end
  end

  f_cc_unit_fcsr_pack u_pack (
    .f_i    (r_q),
    .sel_i  (cr_sel),
    .data_o (cr_data)
  );

endmodule

// File: tb/tb_f_cc_unit.sv
// tb_f_cc_unit: directed plus random stimulus, reference model feeding a
// per-cycle scoreboard queue that a negedge monitor drains.
module tb_f_cc_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        iss_valid;
  logic [2:0]  iss_cc;
  logic        cmp_ready;
  logic        cmp_wait;
  logic        cmp_result;
  logic        cmp_invalid;
  logic        busy;
  logic        rd_valid;
  logic [2:0]  rd_cc;
  logic        rd_tf;
  logic        rd_ready;
  logic        rd_taken;
  logic        cw_valid;
  logic [1:0]  cw_sel;
  logic [31:0] cw_data;
  logic        cw_ready;
  logic [1:0]  cr_sel;
  logic [31:0] cr_data;
  logic        fpe_exc;

  always #5 clk = ~clk;

  f_cc_unit dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .iss_valid(iss_valid), .iss_cc(iss_cc),
    .cmp_ready(cmp_ready), .cmp_wait(cmp_wait),
    .cmp_result(cmp_result), .cmp_invalid(cmp_invalid),
    .busy(busy), .rd_valid(rd_valid), .rd_cc(rd_cc),
    .rd_tf(rd_tf), .rd_ready(rd_ready), .rd_taken(rd_taken),
    .cw_valid(cw_valid), .cw_sel(cw_sel), .cw_data(cw_data),
    .cw_ready(cw_ready), .cr_sel(cr_sel), .cr_data(cr_data),
    .fpe_exc(fpe_exc)
  );

  typedef struct {
    bit        busy;
    bit        cwr;
    bit        rdr;
    bit        taken;
    bit        fpe;
    bit [31:0] cr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference state
  bit       m_fcc[8];
  bit       m_fs;
  bit [5:0] m_cause;
  bit [4:0] m_en;
  bit [4:0] m_flag;
  bit [1:0] m_rm;
  bit       m_pend;
  int       m_pcc;
  bit       m_fpe;

  function automatic bit [31:0] view(bit [1:0] s);
    bit [31:0] v = 0;
    case (s)
      2'd0: begin
        for (int i = 1; i < 8; i++) v[24+i] = m_fcc[i];
        v[23] = m_fcc[0];
        v[24] = m_fs;
        v[17:12] = m_cause;
        v[11:7] = m_en;
        v[6:2] = m_flag;
        v[1:0] = m_rm;
      end
      2'd1: for (int i = 0; i < 8; i++) v[i] = m_fcc[i];
      2'd2: begin
        v[17:12] = m_cause;
        v[6:2] = m_flag;
      end
      default: begin
        v[11:7] = m_en;
        v[2] = m_fs;
        v[1:0] = m_rm;
      end
    endcase
    return v;
  endfunction

  task automatic ctc1(bit [1:0] s, bit [31:0] d);
    case (s)
      2'd0: begin
        m_fcc[0] = d[23];
        for (int i = 1; i < 8; i++) m_fcc[i] = d[24+i];
        m_fs = d[24];
        m_cause = d[17:12];
        m_en = d[11:7];
        m_flag = d[6:2];
        m_rm = d[1:0];
      end
      2'd1: for (int i = 0; i < 8; i++) m_fcc[i] = d[i];
      2'd2: begin
        m_cause = d[17:12];
        m_flag = d[6:2];
      end
      default: begin
        m_en = d[11:7];
        m_fs = d[2];
        m_rm = d[1:0];
      end
    endcase
  endtask

  task automatic idle();
    flush = 0; iss_valid = 0; iss_cc = 0;
    cmp_ready = 0; cmp_wait = 0;
    cmp_result = 0; cmp_invalid = 0;
    rd_valid = 0; rd_cc = 0; rd_tf = 0;
    cw_valid = 0; cw_sel = 0; cw_data = 0;
    cr_sel = 0;
  endtask

  // Predict this cycle's outputs, queue them, then advance the model.
  task automatic step();
    exp_t e;
    bit commit, ok, ex, byp, f;
    commit = m_pend && cmp_ready && !cmp_wait;
    ok = commit && !flush;
    ex = cmp_invalid && m_en[4];
    byp = 0;
`ifdef FCC_BYPASS_EN
    byp = ok && !ex && (m_pcc == int'(rd_cc));
`endif
    e.busy = m_pend;
    e.cwr = !m_pend;
    e.rdr = !(m_pend && m_pcc == int'(rd_cc)) || byp;
    f = byp ? cmp_result : m_fcc[rd_cc];
    e.taken = (f == rd_tf);
    e.fpe = m_fpe;
    e.cr = view(cr_sel);
    q.push_back(e);
    if (resetn) begin
      m_fpe = ok && ex;
      if (ok) begin
        m_cause = 0;
        m_cause[4] = cmp_invalid;
        if (!ex) begin
          m_fcc[m_pcc] = cmp_result;
          m_flag[4] = m_flag[4] | cmp_invalid;
        end
      end
      if (cw_valid && !m_pend) ctc1(cw_sel, cw_data);
      if (flush) m_pend = 0;
      else if (!m_pend) begin
        if (iss_valid) begin
          m_pend = 1;
          m_pcc = int'(iss_cc);
        end
      end else if (commit) begin
        if (iss_valid) m_pcc = int'(iss_cc);
        else m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, bit [31:0] act, bit [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exv, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("busy", 32'(busy), 32'(e.busy));
      chk("cw_ready", 32'(cw_ready), 32'(e.cwr));
      chk("rd_ready", 32'(rd_ready), 32'(e.rdr));
      chk("fpe_exc", 32'(fpe_exc), 32'(e.fpe));
      chk("cr_data", cr_data, e.cr);
      if (e.rdr && rd_ready)
        chk("rd_taken", 32'(rd_taken), 32'(e.taken));
    end
  end

  initial begin
    bit cw_go;
    int budget;
    idle();
    resetn = 0;
    rd_valid = 1; rd_cc = 3; rd_tf = 0;
    @(posedge clk); #1;
    repeat (3) step();
    resetn = 1;
    idle(); step();

    // commit cc3 result 1
    iss_valid = 1; iss_cc = 3; step();
    idle(); cmp_ready = 1; cmp_result = 1; step();
    idle(); cr_sel = 1; rd_valid = 1; rd_cc = 3; rd_tf = 1; step();
    cr_sel = 0; step();

    // stall on pending cc5, other cc proceeds
    idle(); iss_valid = 1; iss_cc = 5; step();
    idle(); rd_valid = 1; rd_cc = 5; rd_tf = 1; step(); step();
    rd_cc = 2; step();
    rd_cc = 5; cmp_ready = 1; cmp_result = 1; step();
    idle(); rd_valid = 1; rd_cc = 5; rd_tf = 1; step();

    // commit held by cmp_wait
    idle(); iss_valid = 1; iss_cc = 6; step();
    idle(); cmp_ready = 1; cmp_wait = 1; cmp_result = 1; cr_sel = 1;
    repeat (3) step();
    cmp_wait = 0; step();
    idle(); cr_sel = 1; step();
    cmp_ready = 1; step();

    // invalid with V enabled: exception, FCC1 unchanged
    idle(); cw_valid = 1; cw_sel = 3; cw_data = 32'h800; step();
    idle(); iss_valid = 1; iss_cc = 1; step();
    idle(); cmp_ready = 1; cmp_invalid = 1; cmp_result = 1; step();
    idle(); cr_sel = 2; step(); step();

    // invalid with V disabled: FCC1 written, flag V set
    idle(); cw_valid = 1; cw_sel = 3; cw_data = 0; step();
    idle(); iss_valid = 1; iss_cc = 1; step();
    idle(); cmp_ready = 1; cmp_invalid = 1; cmp_result = 1; step();
    idle(); step();

    // flush discards commit; CTC1 blocked while busy
    idle(); iss_valid = 1; iss_cc = 0; step();
    idle(); cmp_ready = 1; cmp_result = 1; cmp_invalid = 1;
    flush = 1; cr_sel = 2; step();
    idle(); step();
    iss_valid = 1; iss_cc = 0; step();
    idle(); cw_valid = 1; cw_sel = 1; cw_data = 32'hff; cr_sel = 1;
    step();
    idle(); cmp_ready = 1; cr_sel = 1; step();
    idle(); cw_valid = 1; cw_sel = 1; cw_data = 32'hff; cr_sel = 1;
    step();
    idle(); cr_sel = 1; step();

    // random traffic honouring the issue protocol
    for (int n = 0; n < 2000; n++) begin
      bit cm;
      idle();
      flush = ($urandom % 20) == 0;
      cmp_ready = $urandom % 2;
      cmp_wait = ($urandom % 3) == 0;
      cmp_result = $urandom % 2;
      cmp_invalid = ($urandom % 4) == 0;
      cm = m_pend && cmp_ready && !cmp_wait;
      if (m_pend) iss_valid = cm && ($urandom % 2);
      else iss_valid = ($urandom % 3) == 0;
      iss_cc = 3'($urandom);
      cw_go = ($urandom % 6) == 0;
      cw_valid = cw_go;
      cw_sel = 2'($urandom);
      cw_data = $urandom;
      rd_valid = $urandom % 2;
      rd_cc = 3'($urandom);
      rd_tf = $urandom % 2;
      cr_sel = 2'($urandom);
      step();
    end

    idle();
    step(); step();
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
